// File: rtl/randomizer_stream.sv
// Stream scrambler: XORs DW bits per beat with a two-tap Fibonacci PRBS, reseeding at frame
// boundaries. One registered output stage with valid/ready on both sides.
module randomizer_stream #(
  parameter int unsigned        LFSR_W      = 15,
  parameter int unsigned        TAP_A       = 0,
  parameter int unsigned        TAP_B       = 1,
  parameter logic [LFSR_W-1:0]  SEED        = 15'h3715,
  parameter int unsigned        DW          = 8,
  parameter int unsigned        BLOCK_BEATS = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_bypass,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              sof_abort
);

  localparam int unsigned       CntW    = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  localparam logic [CntW-1:0]   LastCnt = CntW'(BLOCK_BEATS - 1);

  typedef enum logic {StIdle, StFrame} state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   seed_q, seed_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_data_q, out_data_d;
  logic                out_sof_q, out_sof_d;
  logic                out_eof_q, out_eof_d;
  logic                sof_abort_q, sof_abort_d;

  logic                accept;
  logic                restart;
  logic                last_beat;
  logic [DW-1:0]       scrambled;
  logic [LFSR_W-1:0]   lfsr_adv;

  // A new frame starts from the seed: always in IDLE, or when SOF arrives mid-frame.
  assign restart = (state_q == StIdle) || in_sof;

  always_comb begin : scramble
    logic [LFSR_W-1:0] st;
    st        = restart ? seed_q : lfsr_q;
    scrambled = '0;
    for (int i = 0; i < DW; i++) begin
      scrambled[i] = in_data[i] ^ st[TAP_A] ^ st[TAP_B];
      st           = {st[TAP_A] ^ st[TAP_B], st[LFSR_W-1:1]};
    end
    lfsr_adv = st;
  end

  always_comb begin
    in_ready    = !seed_load && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
    last_beat   = !restart && (cnt_q == LastCnt);

    state_d     = state_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    sof_abort_d = 1'b0;

    if (seed_load) begin
      seed_d  = seed_in;
      lfsr_d  = seed_in;
      cnt_d   = '0;
      state_d = StIdle;
    end else if (accept) begin
      out_data_d  = cfg_bypass ? in_data : scrambled;
      out_sof_d   = restart;
      out_eof_d   = last_beat;
      sof_abort_d = (state_q == StFrame) && in_sof;
      if (last_beat) begin
        // Frame end reloads the seed rather than keeping the advanced state.
        lfsr_d  = seed_q;
        cnt_d   = '0;
        state_d = StIdle;
      end else begin
        lfsr_d  = lfsr_adv;
        cnt_d   = restart ? CntW'(1) : cnt_q + CntW'(1);
        state_d = StFrame;
      end
    end

    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      seed_q      <= SEED;
      lfsr_q      <= SEED;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      sof_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      sof_abort_q <= sof_abort_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign sof_abort = sof_abort_q;

endmodule

// File: tb/tb_randomizer_stream.sv
// Bench for randomizer_stream: directed scenarios plus random traffic against a frame-level
// keystream model (position-in-frame, seed, running PRBS state).
module tb_randomizer_stream;

  localparam int unsigned LW   = 15;
  localparam int unsigned DW   = 8;
  localparam int          BB   = 12;
  localparam logic [14:0] SEED = 15'h3715;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_bypass = 1'b0;
  logic        seed_load = 1'b0;
  logic [14:0] seed_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        sof_abort;

  int checks = 0;
  int errors = 0;

  logic [14:0] m_seed, m_lfsr;
  int          m_pos;
  bit          m_full;
  int          ready_mis, stray_abort;
  beat_t       exp_beats[$], obs_beats[$];
  bit          exp_abort[$], obs_abort[$];

  randomizer_stream #(
    .LFSR_W(LW), .TAP_A(0), .TAP_B(1), .SEED(SEED), .DW(DW), .BLOCK_BEATS(BB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_bypass(cfg_bypass), .seed_load(seed_load),
    .seed_in(seed_in), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .sof_abort(sof_abort)
  );

  always #5 clk = ~clk;

  // Frame model: position 0 means no frame open; keystream bit = s[0]^s[1], shifted in at top.
  task automatic model_accept(input logic [7:0] d, input bit sof, input bit byp);
    logic [14:0] st;
    logic [7:0]  ks;
    bit          fresh, eof;
    fresh = (m_pos == 0) || sof;
    st    = fresh ? m_seed : m_lfsr;
    for (int k = 0; k < 8; k++) begin
      ks[k] = st[0] ^ st[1];
      st    = (st >> 1) | (15'(ks[k]) << 14);
    end
    exp_abort.push_back((m_pos != 0) && sof);
    m_pos = fresh ? 1 : m_pos + 1;
    eof   = (m_pos == BB);
    exp_beats.push_back('{data: byp ? d : (d ^ ks), sof: fresh, eof: eof});
    if (eof) begin
      m_pos  = 0;
      m_lfsr = m_seed;
    end else begin
      m_lfsr = st;
    end
  endtask

  // One clock: decide handshake from the model, record observations, advance.
  task automatic step();
    bit m_ready, acc, cons;
    #1;
    m_ready = !seed_load && (!m_full || out_ready);
    if (in_ready !== m_ready) ready_mis++;
    acc  = in_valid && m_ready;
    cons = m_full && out_ready;
    if (cons) begin
      if (out_valid === 1'b1) obs_beats.push_back('{out_data, out_sof, out_eof});
      else obs_beats.push_back('{out_data, 1'bx, 1'bx});
    end
    if (seed_load) begin
      m_seed = seed_in;
      m_lfsr = seed_in;
      m_pos  = 0;
    end else if (acc) begin
      model_accept(in_data, in_sof, cfg_bypass);
    end
    if (acc) m_full = 1'b1;
    else if (cons) m_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (acc) obs_abort.push_back(sof_abort);
    else if (sof_abort !== 1'b0) stray_abort++;
  endtask

  task automatic send(input logic [7:0] d, input bit sof, input bit byp);
    in_valid   = 1'b1;
    in_data    = d;
    in_sof     = sof;
    cfg_bypass = byp;
    step();
  endtask

  task automatic drain();
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    cfg_bypass = 1'b0;
    seed_load  = 1'b0;
    out_ready  = 1'b1;
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; cfg_bypass = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_seed = SEED; m_lfsr = SEED; m_pos = 0; m_full = 1'b0;
    exp_beats.delete(); obs_beats.delete(); exp_abort.delete(); obs_abort.delete();
    ready_mis = 0; stray_abort = 0;
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 1'b0;
    send(8'h3C, 1'b0, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    do_reset();
    #1;
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b want 0", out_sof); end
    if (out_eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b want 0", out_eof); end
    if (sof_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", sof_abort); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    do_reset();
    send(8'h00, 1'b0, 1'b0);
    drain();
    checks++;
    if (obs_beats.size() < 1 || obs_beats[0] !== beat_t'({8'h9F, 1'b1, 1'b0})) begin
      errors++;
      $display("FAIL vec_zero: got %h want %h", obs_beats.size() ? obs_beats[0] : 'x, {8'h9F, 2'b10});
    end
    do_reset();
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    drain();
    checks += 2;
    if (obs_beats.size() < 2) begin
      errors++; $display("FAIL vec_ones_count: got %0d want 2", obs_beats.size());
    end else begin
      if (obs_beats[0].data !== 8'h60) begin
        errors++; $display("FAIL vec_ones_b1: got %h want 60", obs_beats[0].data);
      end
      if (obs_beats[1] !== exp_beats[1]) begin
        errors++; $display("FAIL vec_ones_b2: got %h want %h", obs_beats[1], exp_beats[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1;
    do_reset();
    d1 = 8'($urandom);
    for (int b = 0; b < 13; b++) begin
      if (b >= 1) begin
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", b, out_valid);
        end
      end
      send((b == 0 || b == 12) ? d1 : 8'($urandom), 1'b0, 1'b0);
    end
    drain();
    checks++;
    if (obs_beats.size() !== exp_beats.size()) begin
      errors++; $display("FAIL b2b_count: got %0d want %0d", obs_beats.size(), exp_beats.size());
    end
    foreach (exp_beats[i]) if (i < obs_beats.size()) begin
      checks++;
      if (obs_beats[i] !== exp_beats[i]) begin
        errors++; $display("FAIL b2b_beat[%0d]: got %h want %h", i, obs_beats[i], exp_beats[i]);
      end
    end
    checks++;
    if (obs_beats.size() < 13 || obs_beats[12] !== beat_t'({exp_beats[0].data, 1'b1, 1'b0})) begin
      errors++; $display("FAIL b2b_reseed: beat 13 differs from beat 1 want %h", exp_beats[0]);
    end
  endtask

  task automatic test_sof_abort();
    logic [7:0] d1;
    do_reset();
    d1 = 8'($urandom);
    for (int b = 0; b < 17; b++) send((b == 0 || b == 4) ? d1 : 8'($urandom), b == 4, 1'b0);
    drain();
    checks++;
    if (obs_abort.size() !== exp_abort.size()) begin
      errors++; $display("FAIL abort_count: got %0d want %0d", obs_abort.size(), exp_abort.size());
    end
    foreach (exp_abort[i]) if (i < obs_abort.size()) begin
      checks++;
      if (obs_abort[i] !== exp_abort[i]) begin
        errors++; $display("FAIL abort[%0d]: got %b want %b", i, obs_abort[i], exp_abort[i]);
      end
    end
    foreach (exp_beats[i]) if (i < obs_beats.size()) begin
      checks++;
      if (obs_beats[i] !== exp_beats[i]) begin
        errors++; $display("FAIL abort_beat[%0d]: got %h want %h", i, obs_beats[i], exp_beats[i]);
      end
    end
    checks += 2;
    if (obs_beats.size() < 16 || obs_beats[4] !== beat_t'({exp_beats[0].data, 1'b1, 1'b0})) begin
      errors++; $display("FAIL abort_restart: beat 5 not a restart want %h", exp_beats[0]);
    end
    if (obs_beats.size() < 16 || obs_beats[15].eof !== 1'b1 || stray_abort !== 0) begin
      errors++; $display("FAIL abort_frame_end: eof missing at beat 16 or stray=%0d", stray_abort);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send(8'($urandom), 1'b0, 1'b0);
    in_data = 8'($urandom);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", c, in_ready); end
      if (out_valid !== 1'b1 || {out_data, out_sof, out_eof} !== exp_beats[0]) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %b %h want 1 %h", c, out_valid,
                 {out_data, out_sof, out_eof}, exp_beats[0]);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    drain();
    checks += 2;
    if (obs_beats.size() !== 2 || obs_beats[0] !== exp_beats[0] || obs_beats[1] !== exp_beats[1]) begin
      errors++; $display("FAIL bp_stream: got %0d beats want 2 matching model", obs_beats.size());
    end
    if (ready_mis !== 0) begin errors++; $display("FAIL bp_ready_model: got %0d want 0", ready_mis); end
  endtask

  task automatic test_seed_bypass();
    do_reset();
    for (int b = 0; b < 3; b++) send(8'($urandom), 1'b0, 1'b0);
    seed_in = 15'h0001;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    send(8'h00, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b1);
    send(8'($urandom), 1'b0, 1'b0);
    drain();
    checks += 3;
    if (obs_beats.size() < 6) begin
      errors++; $display("FAIL seed_count: got %0d want 6", obs_beats.size());
    end else begin
      if (obs_beats[3] !== beat_t'({8'h01, 1'b1, 1'b0})) begin
        errors++; $display("FAIL seed_one: got %h want %h", obs_beats[3], {8'h01, 2'b10});
      end
      if (obs_beats[4].data !== 8'hA5) begin
        errors++; $display("FAIL bypass_data: got %h want a5", obs_beats[4].data);
      end
      if (obs_beats[5] !== exp_beats[5]) begin
        errors++; $display("FAIL bypass_advance: got %h want %h", obs_beats[5], exp_beats[5]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_data    = 8'($urandom);
      in_sof     = ($urandom_range(0, 19) == 0);
      cfg_bypass = ($urandom_range(0, 4) == 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      seed_load  = ($urandom_range(0, 59) == 0);
      seed_in    = 15'($urandom_range(1, 32767));
      step();
    end
    drain();
    checks += 3;
    if (obs_beats.size() !== exp_beats.size()) begin
      errors++; $display("FAIL rnd_count: got %0d want %0d", obs_beats.size(), exp_beats.size());
    end
    if (ready_mis !== 0) begin errors++; $display("FAIL rnd_ready: got %0d want 0", ready_mis); end
    if (stray_abort !== 0) begin errors++; $display("FAIL rnd_stray: got %0d want 0", stray_abort); end
    foreach (exp_beats[i]) if (i < obs_beats.size()) begin
      checks++;
      if (obs_beats[i] !== exp_beats[i]) begin
        errors++; $display("FAIL rnd_beat[%0d]: got %h want %h", i, obs_beats[i], exp_beats[i]);
      end
    end
    foreach (exp_abort[i]) if (i < obs_abort.size()) begin
      checks++;
      if (obs_abort[i] !== exp_abort[i]) begin
        errors++; $display("FAIL rnd_abort[%0d]: got %b want %b", i, obs_abort[i], exp_abort[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_sof_abort();
    test_backpressure();
    test_seed_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
